// File: rtl/seq_oe_sort.sv
// seq_oe_sort: sequential odd-even transposition sorter.
//
// Sorts NUM unsigned DW-bit elements. One compare-exchange phase runs per
// clock, so NUM/2 comparators serve all phases. Each transaction carries its
// own direction bit. The block also returns the stable permutation (argsort):
// the original index of every output element.
//
// Optional feature: define SEQ_OE_SORT_EARLY_EXIT_EN to enable early exit.
// The sort then stops after two consecutive phases that swap nothing, and the
// early_o port reports that the sort ended early.
//
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   in_valid   input vector valid
//   in_ready   block can accept a vector (high only in IDLE)
//   data_i     packed input, element k at [k*DW +: DW]
//   mode_i     0 = ascending, 1 = descending, sampled with data_i
//   out_valid  sorted result valid (high in DONE)
//   out_ready  consumer accepts the result
//   data_o     sorted vector, element k at [k*DW +: DW], k=0 first in order
//   idx_o      original index of each output element, element k at [k*IW +: IW]
//   busy       high in SORT or DONE
//   early_o    (macro only) 1 when the last result ended early
//
// Handshake: a transfer happens on a rising edge where valid && ready. When
// out_valid is high it stays high, with data_o and idx_o stable, until it is
// accepted. The producer may raise in_valid at any time. in_valid is ignored
// while in_ready is low.
module seq_oe_sort #(
  parameter int DW = 8,
  parameter int NUM = 8,
  localparam int IW = (NUM <= 2) ? 1 : $clog2(NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW*NUM-1:0] data_i,
  input  logic              mode_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW*NUM-1:0] data_o,
  output logic [IW*NUM-1:0] idx_o,
`ifdef SEQ_OE_SORT_EARLY_EXIT_EN
  output logic              early_o,
`endif
  output logic              busy
);

  localparam int NC = NUM / 2;

  typedef enum logic [1:0] {S_IDLE, S_SORT, S_DONE} state_t;

  // FSM state, exposed for debug probing.
  state_t state, state_nxt;

  logic [DW-1:0] elem_q [NUM];
  logic [IW-1:0] idx_q  [NUM];
  logic [DW-1:0] elem_nx [NUM];
  logic [IW-1:0] idx_nx  [NUM];
  logic          mode_q;
  logic [IW-1:0] cnt_q;
  // Set once the final phase has been applied. The following SORT cycle is
  // the DONE-entry cycle.
  logic          last_q;
`ifdef SEQ_OE_SORT_EARLY_EXIT_EN
  logic          prev_zero_q;
  logic          early_q;
`endif

  logic          odd;
  logic [NC-1:0] swap;
  logic [DW-1:0] op_a [NC];
  logic [DW-1:0] op_b [NC];

  assign odd = cnt_q[0];

  // Comparator c serves pair (2c,2c+1) in even phases and (2c+1,2c+2) in odd
  // phases. When NUM is even, the last comparator has no odd pair and stays idle.
  for (genvar c = 0; c < NC; c++) begin : g_cmp
    localparam bit O_OK = (2*c + 2 < NUM);
    localparam int HI_O = O_OK ? 2*c + 2 : 2*c + 1;
    assign op_a[c] = odd ? elem_q[2*c + 1] : elem_q[2*c];
    assign op_b[c] = odd ? elem_q[HI_O] : elem_q[2*c + 1];
    // Strict comparison: equal values stay in place, which keeps the sort stable.
    assign swap[c] = (!odd || O_OK) &&
                     (mode_q ? (op_a[c] < op_b[c]) : (op_a[c] > op_b[c]));
  end

  // Position k takes its partner's value when the comparator that covers it
  // in this phase swaps. Unpaired end elements keep their value.
  for (genvar k = 0; k < NUM; k++) begin : g_pos
    localparam bit E_EX = ((k / 2) < NC);
    localparam int EC   = E_EX ? k / 2 : 0;
    localparam int EP   = !E_EX ? k : ((k % 2 == 0) ? k + 1 : k - 1);
    localparam bit O_EX = (k % 2 == 1) ? (k + 1 < NUM) : (k > 0);
    localparam int OC   = !O_EX ? 0 : ((k % 2 == 1) ? (k - 1) / 2 : k / 2 - 1);
    localparam int OP   = !O_EX ? k : ((k % 2 == 1) ? k + 1 : k - 1);
    logic take;
    assign take       = odd ? (O_EX && swap[OC]) : (E_EX && swap[EC]);
    assign elem_nx[k] = take ? (odd ? elem_q[OP] : elem_q[EP]) : elem_q[k];
    assign idx_nx[k]  = take ? (odd ? idx_q[OP] : idx_q[EP]) : idx_q[k];
    assign data_o[k*DW +: DW] = elem_q[k];
    assign idx_o[k*IW +: IW]  = idx_q[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_SORT;
      end
      S_SORT: begin
        busy = 1'b1;
        if (last_q) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM; k++) begin
        elem_q[k] <= '0;
        idx_q[k]  <= '0;
      end
      mode_q <= 1'b0;
      cnt_q  <= '0;
      last_q <= 1'b0;
`ifdef SEQ_OE_SORT_EARLY_EXIT_EN
      prev_zero_q <= 1'b0;
      early_q     <= 1'b0;
`endif
    end else begin
      if (state == S_IDLE && in_valid) begin
        for (int k = 0; k < NUM; k++) begin
          elem_q[k] <= data_i[k*DW +: DW];
          idx_q[k]  <= IW'(k);
        end
        mode_q <= mode_i;
        cnt_q  <= '0;
        last_q <= 1'b0;
`ifdef SEQ_OE_SORT_EARLY_EXIT_EN
        prev_zero_q <= 1'b0;
        early_q     <= 1'b0;
`endif
      end else if (state == S_SORT && !last_q) begin
        for (int k = 0; k < NUM; k++) begin
          elem_q[k] <= elem_nx[k];
          idx_q[k]  <= idx_nx[k];
        end
        cnt_q <= cnt_q + IW'(1);
        if (cnt_q == IW'(NUM - 1)) last_q <= 1'b1;
`ifdef SEQ_OE_SORT_EARLY_EXIT_EN
        prev_zero_q <= ~(|swap);
        if (~(|swap) && prev_zero_q && cnt_q != IW'(NUM - 1)) begin
          last_q  <= 1'b1;
          early_q <= 1'b1;
        end
`endif
      end
    end
  end

`ifdef SEQ_OE_SORT_EARLY_EXIT_EN
  assign early_o = early_q;
`endif

endmodule

// File: tb/tb_seq_oe_sort.sv
// tb_seq_oe_sort: directed and scoreboard-checked bench for seq_oe_sort
// with DW=8 and NUM=8. Expected results come from a selection-sort model that
// picks the first minimum or maximum and pushes the result when stimulus is
// driven. The result is popped and compared when the DUT presents out_valid.
module tb_seq_oe_sort;

  localparam int DW  = 8;
  localparam int NUM = 8;
  localparam int IW  = 3;
  localparam int W   = DW*NUM + IW*NUM;
`ifdef SEQ_OE_SORT_EARLY_EXIT_EN
  localparam int LAT_FULL = 0;  // latency depends on the data; checked separately
`else
  localparam int LAT_FULL = NUM + 1;
`endif

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DW*NUM-1:0] data_i;
  logic              mode_i;
  logic              out_valid;
  logic              out_ready;
  logic [DW*NUM-1:0] data_o;
  logic [IW*NUM-1:0] idx_o;
  logic              busy;
`ifdef SEQ_OE_SORT_EARLY_EXIT_EN
  logic              early_o;
`endif

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  seq_oe_sort #(.DW(DW), .NUM(NUM)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_i(data_i), .mode_i(mode_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_o(data_o), .idx_o(idx_o),
`ifdef SEQ_OE_SORT_EARLY_EXIT_EN
    .early_o(early_o),
`endif
    .busy(busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW*NUM-1:0] mk8(input int e0, e1, e2, e3, e4, e5, e6, e7);
    return {8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  function automatic logic [IW*NUM-1:0] mki8(input int e0, e1, e2, e3, e4, e5, e6, e7);
    return {3'(e7), 3'(e6), 3'(e5), 3'(e4), 3'(e3), 3'(e2), 3'(e1), 3'(e0)};
  endfunction

  // Stable selection sort: scans in index order and replaces the pick only
  // when strictly better, so the earliest of equal values comes out first.
  function automatic logic [W-1:0] model(input logic [DW*NUM-1:0] d, input logic m);
    logic [DW*NUM-1:0] rd;
    logic [IW*NUM-1:0] ri;
    bit used [NUM];
    int best;
    rd = '0;
    ri = '0;
    for (int k = 0; k < NUM; k++) used[k] = 1'b0;
    for (int o = 0; o < NUM; o++) begin
      best = -1;
      for (int k = 0; k < NUM; k++) begin
        if (!used[k]) begin
          if (best < 0) best = k;
          else if (m ? (d[k*DW +: DW] > d[best*DW +: DW])
                     : (d[k*DW +: DW] < d[best*DW +: DW])) best = k;
        end
      end
      used[best] = 1'b1;
      rd[o*DW +: DW] = d[best*DW +: DW];
      ri[o*IW +: IW] = IW'(best);
    end
    return {ri, rd};
  endfunction

  // ---------------- driver / scoreboard ----------------
  task automatic run_vec(input logic [DW*NUM-1:0] d, input logic m, input int exp_lat,
                         input int hold, input string tag);
    int n;
    int lat;
    bit stable;
    bit ignored;
    logic [W-1:0] snap;
    logic [W-1:0] exp;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check({tag, "_in_ready"}, in_ready, 1'b1);
    data_i   = d;
    mode_i   = m;
    in_valid = 1'b1;
    exp_q.push_back(model(d, m));
    step();
    in_valid = 1'b0;
    data_i   = {$urandom, $urandom};
    mode_i   = ~m;
    check({tag, "_busy"}, {busy, in_ready}, 2'b10);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    check({tag, "_valid"}, out_valid, 1'b1);
    if (exp_lat > 0) check({tag, "_latency"}, lat, exp_lat);
    if (hold > 0) begin
      snap    = {idx_o, data_o};
      stable  = 1'b1;
      ignored = 1'b1;
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'($urandom_range(0, 1));
        data_i   = {$urandom, $urandom};
        step();
        if (!out_valid || {idx_o, data_o} !== snap) stable = 1'b0;
        if (in_ready) ignored = 1'b0;
      end
      in_valid = 1'b0;
      check({tag, "_hold_stable"}, stable, 1'b1);
      check({tag, "_hold_no_ready"}, ignored, 1'b1);
    end
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, exp_q.size(), 1);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    check({tag, "_result"}, {idx_o, data_o}, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_after_hs"}, {out_valid, in_ready, busy}, 3'b010);
    check({tag, "_held_idle"}, {idx_o, data_o}, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_i    = '0;
    mode_i    = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_data", data_o, '0);
    check("rst_idx", idx_o, '0);

    run_vec(mk8(5, 3, 9, 1, 7, 2, 8, 4), 1'b0, LAT_FULL, 0, "asc");
    check("asc_data", data_o, mk8(1, 2, 3, 4, 5, 7, 8, 9));
    check("asc_idx", idx_o, mki8(3, 5, 1, 7, 0, 4, 6, 2));

    run_vec(mk8(4, 4, 1, 9, 1, 9, 0, 4), 1'b1, LAT_FULL, 20, "desc_dup");
    check("desc_data", data_o, mk8(9, 9, 4, 4, 4, 1, 1, 0));
    check("desc_idx", idx_o, mki8(3, 5, 0, 1, 7, 2, 4, 6));

    // Reset three cycles into a sort drops the partial result.
    data_i   = mk8(200, 100, 50, 25, 12, 6, 3, 1);
    mode_i   = 1'b0;
    in_valid = 1'b1;
    exp_q.push_back(model(data_i, mode_i));
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    #1;
    check("midrst_flags", {in_ready, out_valid, busy}, 3'b100);
    check("midrst_data", data_o, '0);
    check("midrst_idx", idx_o, '0);
    void'(exp_q.pop_back());
    step();
    rst = 1'b0;
    step();
    run_vec(mk8(9, 0, 255, 128, 127, 1, 254, 2), 1'b1, LAT_FULL, 0, "post_rst");

    // Boundary values: all equal, and extremes interleaved.
    run_vec(mk8(7, 7, 7, 7, 7, 7, 7, 7), 1'b0, LAT_FULL, 0, "all_equal");
    check("all_equal_idx", idx_o, mki8(0, 1, 2, 3, 4, 5, 6, 7));
    run_vec(mk8(255, 0, 255, 0, 255, 0, 255, 0), 1'b0, LAT_FULL, 2, "extremes");

    for (int t = 0; t < 6; t++) begin
      logic [DW*NUM-1:0] rv;
      for (int k = 0; k < NUM; k++)
        rv[k*DW +: DW] = (t < 3) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      run_vec(rv, 1'($urandom_range(0, 1)), LAT_FULL, $urandom_range(0, 3), "random");
    end

`ifdef SEQ_OE_SORT_EARLY_EXIT_EN
    run_vec(mk8(0, 1, 2, 3, 4, 5, 6, 7), 1'b0, 3, 0, "early_sorted");
    check("early_sorted_flag", early_o, 1'b1);
    run_vec(mk8(7, 6, 5, 4, 3, 2, 1, 0), 1'b0, NUM + 1, 0, "early_reversed");
    check("early_reversed_flag", early_o, 1'b0);
`endif

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
